// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide engine: shift-add multiply and restoring divide
// on operand magnitudes, followed by one sign-correction cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       multiDiv,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               negate;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];
  assign negate = sign_a_q ^ sign_b_q;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;

    accept = ((state_q == StIdle) || (state_q == StDone)) && start &&
             ((multiDiv == 2'b01) || (multiDiv == 2'b10));

    // Multiply: low half holds the remaining multiplier bits, product grows in from the top.
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_mag_q : {WIDTH{1'b0}})};
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_mag_q};
    prod      = negate ? -acc_q : acc_q;

    case (state_q)
      StCalc: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        dbz_d   = 1'b0;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_mag_q == '0) begin
          lo_d  = '1;
          hi_d  = sign_a_q ? -a_mag_q : a_mag_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = negate ? -acc_lo : acc_lo;
          hi_d = sign_a_q ? -acc_hi : acc_hi;
        end
      end
      default: begin
        state_d = StIdle;
        if (accept) begin
          state_d  = StCalc;
          is_div_d = multiDiv[1];
          sign_a_d = op_a[WIDTH-1];
          sign_b_d = op_b[WIDTH-1];
          a_mag_d  = op_a[WIDTH-1] ? -op_a : op_a;
          b_mag_d  = op_b[WIDTH-1] ? -op_b : op_b;
          acc_d    = {{WIDTH{1'b0}}, (multiDiv[1] ? a_mag_d : b_mag_d)};
          cnt_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written corner
// sequences and randomized operations against an integer-arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   multiDiv;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .multiDiv   (multiDiv),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [1:0]   md;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on wide values.
  function automatic void model(input logic [1:0] md, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] lo,
                                output logic [W-1:0] hi, output logic dbz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    if (md == 2'b01) begin
      p  = sa * sb;
      lo = p[W-1:0];
      hi = p[2*W-1:W];
    end else if (sb == 0) begin
      lo  = '1;
      hi  = a;
      dbz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b);
    multiDiv = md;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // cyc counts cycles with the accept cycle as 0; stops on done or a bound.
  task automatic wait_done(input int first, output int cyc, output int busy_low);
    cyc = first;
    busy_low = 0;
    while (!done && cyc < 60) begin
      if (!busy) busy_low++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int cyc, bl;
    issue(v.md, v.a, v.b);
    wait_done(1, cyc, bl);
    chk({name, " latency"}, cyc, W + 2);
    chk({name, " busy gap"}, bl, 0);
    chk({name, " busy at done"}, {31'd0, busy}, 0);
    chk({name, " lo"}, {16'd0, result_lo}, {16'd0, v.lo});
    chk({name, " hi"}, {16'd0, result_hi}, {16'd0, v.hi});
    chk({name, " dbz"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
    @(posedge clk);
    #1;
    chk({name, " done pulse"}, {31'd0, done}, 0);
  endtask

  task automatic watch(input int n, output int dones, output int busys);
    dones = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (busy) busys++;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int   cyc, bl, nd, nb;
    vec_t v;
    logic [W-1:0] corners[4];

    vecs[0] = '{2'b01, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0};
    vecs[1] = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
    vecs[2] = '{2'b10, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[3] = '{2'b10, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[4] = '{2'b10, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1};
    vecs[5] = '{2'b01, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 1'b0};
    vecs[6] = '{2'b10, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
    vecs[7] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[8] = '{2'b10, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1};
    corners = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0001};

    rst_n = 1'b0;
    start = 1'b0;
    multiDiv = 2'b00;
    op_a = '0;
    op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset lo", {16'd0, result_lo}, 0);
    chk("reset hi", {16'd0, result_hi}, 0);
    chk("reset dbz", {31'd0, div_by_zero}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Invalid function codes are ignored.
    for (int m = 0; m < 2; m++) begin
      multiDiv = (m == 0) ? 2'b00 : 2'b11;
      op_a = 16'h1234;
      op_b = 16'h0002;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      watch(25, nd, nb);
      chk($sformatf("invalid md%0d done", m), nd, 0);
      chk($sformatf("invalid md%0d busy", m), nb, 0);
      chk($sformatf("invalid md%0d lo held", m), {16'd0, result_lo}, 16'hFFFF);
    end

    // Start during busy is ignored; the single done carries the first result.
    issue(2'b01, 16'd5, 16'd6);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    multiDiv = 2'b10;
    op_a = 16'd9;
    op_b = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 16'd77;
    wait_done(5, cyc, bl);
    chk("busy-start latency", cyc, W + 2);
    chk("busy-start lo", {16'd0, result_lo}, 30);
    chk("busy-start hi", {16'd0, result_hi}, 0);
    watch(25, nd, nb);
    chk("busy-start extra done", nd, 0);
    chk("busy-start extra busy", nb, 0);

    // Back-to-back: new start accepted in the done cycle.
    issue(2'b01, 16'd3, 16'd4);
    wait_done(1, cyc, bl);
    chk("b2b first lo", {16'd0, result_lo}, 12);
    issue(2'b10, 16'd20, 16'd3);
    chk("b2b busy next", {31'd0, busy}, 1);
    wait_done(1, cyc, bl);
    chk("b2b latency", cyc, W + 2);
    chk("b2b lo", {16'd0, result_lo}, 6);
    chk("b2b hi", {16'd0, result_hi}, 2);
    @(posedge clk);
    #1;

    // Reset in the fifth CALC cycle aborts silently.
    run_vec("pre-reset", vecs[4]);
    issue(2'b01, 16'd7, 16'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort lo", {16'd0, result_lo}, 0);
    chk("abort hi", {16'd0, result_hi}, 0);
    chk("abort dbz", {31'd0, div_by_zero}, 0);
    watch(30, nd, nb);
    chk("abort done", nd, 0);
    run_vec("post-reset", vecs[5]);

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      v.md = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      v.a  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      v.b  = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      model(v.md, v.a, v.b, v.lo, v.hi, v.dbz);
      issue(v.md, v.a, v.b);
      wait_done(1, cyc, bl);
      chk($sformatf("rnd%0d latency", i), cyc, W + 2);
      if (result_lo !== v.lo || result_hi !== v.hi || div_by_zero !== v.dbz) begin
        checks++;
        failures++;
        $display("FAIL rnd%0d md=%0b a=%h b=%h: got lo=%h hi=%h dbz=%b expected lo=%h hi=%h dbz=%b",
                 i, v.md, v.a, v.b, result_lo, result_hi, div_by_zero, v.lo, v.hi, v.dbz);
      end else begin
        checks++;
      end
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
